// File: rtl/ama_riscv_decode_queue.sv
// ama_riscv_decode_queue
// Instruction buffer and registered decode stage between fetch and execute.
// Fetched {inst, pc} pairs go into a small circular FIFO. The head is decoded
// combinationally and captured in an output register that is delivered to
// execute under a valid/ready handshake. When the FIFO is empty, an incoming
// word is bypassed straight into the output register.

package ama_riscv_pkg;

    // Major opcodes recognised by the decoder
    localparam logic [6:0] OPC_R       = 7'b011_0011;
    localparam logic [6:0] OPC_I       = 7'b001_0011;
    localparam logic [6:0] OPC_LOAD    = 7'b000_0011;
    localparam logic [6:0] OPC_STORE   = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH  = 7'b110_0011;
    localparam logic [6:0] OPC_JAL     = 7'b110_1111;
    localparam logic [6:0] OPC_JALR    = 7'b110_0111;
    localparam logic [6:0] OPC_LUI     = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC   = 7'b001_0111;
    localparam logic [6:0] OPC_CUSTOM  = 7'b000_1011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b111_0011;

    // Next-PC source selection for the frontend
    localparam logic [1:0] PC_SEL_INC4   = 2'd0;
    localparam logic [1:0] PC_SEL_ALU    = 2'd1;
    localparam logic [1:0] PC_SEL_BP     = 2'd2;
    localparam logic [1:0] PC_SEL_JAL_BP = 2'd3;

    // Immediate format selection
    localparam logic [2:0] IG_NONE = 3'd0;
    localparam logic [2:0] IG_I    = 3'd1;
    localparam logic [2:0] IG_S    = 3'd2;
    localparam logic [2:0] IG_B    = 3'd3;
    localparam logic [2:0] IG_J    = 3'd4;
    localparam logic [2:0] IG_U    = 3'd5;

    // Writeback source selection
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    // ALU operation used by LUI to forward the immediate unchanged
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_a_sel;   // 0: rs1, 1: pc
        logic       alu_b_sel;   // 0: rs2, 1: immediate
        logic [2:0] ig_sel;
        logic       bc_uns;
        logic       dmem_en;
        logic       dmem_we;
        logic       rd_we;
        logic [1:0] wb_sel;
        logic       csr_en;
        logic       custom_en;
    } decoder_t;

    typedef struct packed {
        logic [1:0] pc_sel;
        logic       pc_we;
        logic       branch_inst;
        logic       jump_inst;
    } fe_ctrl_t;

    localparam decoder_t DECODER_INIT_VAL = '{
        alu_op:    ALU_ADD,
        alu_a_sel: 1'b0,
        alu_b_sel: 1'b0,
        ig_sel:    IG_NONE,
        bc_uns:    1'b0,
        dmem_en:   1'b0,
        dmem_we:   1'b0,
        rd_we:     1'b0,
        wb_sel:    WB_ALU,
        csr_en:    1'b0,
        custom_en: 1'b0
    };

    localparam fe_ctrl_t FE_CTRL_INIT_VAL = '{
        pc_sel:      PC_SEL_INC4,
        pc_we:       1'b1,
        branch_inst: 1'b0,
        jump_inst:   1'b0
    };

endpackage

// Combinational decoder: control bundles plus an illegal-instruction flag.
// Anything outside the supported opcode set keeps the INIT bundles.
module ama_riscv_decoder
    import ama_riscv_pkg::*;
(
    input  logic [31:0] inst_i,
    output decoder_t    decoded_o,
    output fe_ctrl_t    fe_ctrl_o,
    output logic        illegal_o
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic       funct7_b5_s;
    logic       unused_inst_bits_s;

    assign opcode_s    = inst_i[6:0];
    assign funct3_s    = inst_i[14:12];
    assign funct7_b5_s = inst_i[30];
    // Register and immediate fields are consumed downstream, not here
    assign unused_inst_bits_s = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

    // Opcode decode into control bundles; unknown encodings flag illegal
    always_comb begin
        decoded_o = DECODER_INIT_VAL;
        fe_ctrl_o = FE_CTRL_INIT_VAL;
        illegal_o = 1'b0;
        if (inst_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (opcode_s)
                OPC_R: begin
                    decoded_o.alu_op = {funct7_b5_s, funct3_s};
                    decoded_o.rd_we  = 1'b1;
                end
                OPC_I: begin
                    // Only the shift-right encoding uses bit 30 as an op bit
                    decoded_o.alu_op    = {(funct3_s == 3'b101) && funct7_b5_s, funct3_s};
                    decoded_o.alu_b_sel = 1'b1;
                    decoded_o.ig_sel    = IG_I;
                    decoded_o.rd_we     = 1'b1;
                end
                OPC_LOAD: begin
                    decoded_o.alu_b_sel = 1'b1;
                    decoded_o.ig_sel    = IG_I;
                    decoded_o.dmem_en   = 1'b1;
                    decoded_o.rd_we     = 1'b1;
                    decoded_o.wb_sel    = WB_MEM;
                end
                OPC_STORE: begin
                    decoded_o.alu_b_sel = 1'b1;
                    decoded_o.ig_sel    = IG_S;
                    decoded_o.dmem_en   = 1'b1;
                    decoded_o.dmem_we   = 1'b1;
                end
                OPC_BRANCH: begin
                    decoded_o.alu_a_sel   = 1'b1;
                    decoded_o.alu_b_sel   = 1'b1;
                    decoded_o.ig_sel      = IG_B;
                    decoded_o.bc_uns      = funct3_s[1];
                    fe_ctrl_o.pc_sel      = PC_SEL_BP;
                    fe_ctrl_o.branch_inst = 1'b1;
                end
                OPC_JAL: begin
                    decoded_o.alu_a_sel = 1'b1;
                    decoded_o.alu_b_sel = 1'b1;
                    decoded_o.ig_sel    = IG_J;
                    decoded_o.rd_we     = 1'b1;
                    decoded_o.wb_sel    = WB_PC4;
                    fe_ctrl_o.pc_sel    = PC_SEL_JAL_BP;
                    fe_ctrl_o.jump_inst = 1'b1;
                end
                OPC_JALR: begin
                    decoded_o.alu_b_sel = 1'b1;
                    decoded_o.ig_sel    = IG_I;
                    decoded_o.rd_we     = 1'b1;
                    decoded_o.wb_sel    = WB_PC4;
                    fe_ctrl_o.pc_sel    = PC_SEL_ALU;
                    fe_ctrl_o.jump_inst = 1'b1;
                end
                OPC_LUI: begin
                    decoded_o.alu_op    = ALU_PASS_B;
                    decoded_o.alu_b_sel = 1'b1;
                    decoded_o.ig_sel    = IG_U;
                    decoded_o.rd_we     = 1'b1;
                end
                OPC_AUIPC: begin
                    decoded_o.alu_a_sel = 1'b1;
                    decoded_o.alu_b_sel = 1'b1;
                    decoded_o.ig_sel    = IG_U;
                    decoded_o.rd_we     = 1'b1;
                end
                OPC_CUSTOM: begin
                    decoded_o.custom_en = 1'b1;
                    decoded_o.rd_we     = 1'b1;
                end
                OPC_SYSTEM: begin
                    // funct3 == 0 covers ecall/ebreak, which write no register
                    decoded_o.csr_en = 1'b1;
                    decoded_o.rd_we  = (funct3_s != 3'b000);
                    decoded_o.wb_sel = WB_CSR;
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

endmodule

module ama_riscv_decode_queue
    import ama_riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [31:0]                in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc,
    output decoder_t                   out_decoded,
    output fe_ctrl_t                   out_fe_ctrl,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+2)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = $clog2(DEPTH + 2);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // FIFO storage and bookkeeping
    logic [31:0]      fifo_inst_q [DEPTH];
    logic [31:0]      fifo_pc_q   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Output stage
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_inst_q;
    logic [31:0]      out_pc_q;
    decoder_t         out_decoded_q;
    fe_ctrl_t         out_fe_ctrl_q;
    logic             out_illegal_q;
    logic             in_ready_q, in_ready_d;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;

    // Handshake and steering
    logic             push_s;
    logic             pop_s;
    logic             out_free_s;
    logic             fifo_empty_s;
    logic             fifo_wr_s;
    logic             fifo_rd_s;
    logic             load_out_s;
    logic [31:0]      sel_inst_s;
    logic [31:0]      sel_pc_s;
    decoder_t         sel_decoded_s;
    fe_ctrl_t         sel_fe_ctrl_s;
    logic             sel_illegal_s;

    assign push_s       = in_valid && in_ready_q && !flush;
    assign pop_s        = out_valid_q && out_ready;
    assign out_free_s   = !out_valid_q || pop_s;
    assign fifo_empty_s = (cnt_q == {CNT_W{1'b0}});

    // The FIFO head always wins; the input is only bypassed when nothing is queued
    assign sel_inst_s = fifo_empty_s ? in_inst : fifo_inst_q[rd_ptr_q];
    assign sel_pc_s   = fifo_empty_s ? in_pc   : fifo_pc_q[rd_ptr_q];

    ama_riscv_decoder u_decoder (
        .inst_i    (sel_inst_s),
        .decoded_o (sel_decoded_s),
        .fe_ctrl_o (sel_fe_ctrl_s),
        .illegal_o (sel_illegal_s)
    );

    // Next-state steering: flush first, then output refill, then FIFO write
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        fifo_wr_s   = 1'b0;
        fifo_rd_s   = 1'b0;
        load_out_s  = 1'b0;
        if (flush) begin
            wr_ptr_d    = {PTR_W{1'b0}};
            rd_ptr_d    = {PTR_W{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            out_valid_d = 1'b0;
        end else begin
            if (out_free_s) begin
                if (!fifo_empty_s) begin
                    fifo_rd_s   = 1'b1;
                    load_out_s  = 1'b1;
                    out_valid_d = 1'b1;
                end else if (push_s) begin
                    load_out_s  = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else begin
                out_valid_d = out_valid_q;
            end
            // A bypassed push is consumed by the output register, not the FIFO
            if (push_s && !(out_free_s && fifo_empty_s)) begin
                fifo_wr_s = 1'b1;
            end else begin
                fifo_wr_s = 1'b0;
            end
            if (fifo_wr_s) begin
                wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (fifo_rd_s) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            cnt_d = cnt_q + CNT_W'(fifo_wr_s) - CNT_W'(fifo_rd_s);
        end
        in_ready_d  = (cnt_d < CNT_W'(DEPTH));
        occupancy_d = OCC_W'(cnt_d) + OCC_W'(out_valid_d);
    end

    // FIFO payload storage; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            fifo_inst_q[wr_ptr_q] <= in_inst;
            fifo_pc_q[wr_ptr_q]   <= in_pc;
        end
    end

    // FIFO pointers, count, and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= {OCC_W{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Output register: word, PC and decode results captured together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_inst_q    <= NOP_INST;
            out_pc_q      <= 32'h0000_0000;
            out_decoded_q <= DECODER_INIT_VAL;
            out_fe_ctrl_q <= FE_CTRL_INIT_VAL;
            out_illegal_q <= 1'b0;
        end else if (load_out_s) begin
            out_inst_q    <= sel_inst_s;
            out_pc_q      <= sel_pc_s;
            out_decoded_q <= sel_decoded_s;
            out_fe_ctrl_q <= sel_fe_ctrl_s;
            out_illegal_q <= sel_illegal_s;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_inst    = out_inst_q;
    assign out_pc      = out_pc_q;
    assign out_decoded = out_decoded_q;
    assign out_fe_ctrl = out_fe_ctrl_q;
    assign out_illegal = out_illegal_q;
    assign occupancy   = occupancy_q;

endmodule

// File: tb/tb_ama_riscv_decode_queue.sv
// Directed testbench for ama_riscv_decode_queue (DEPTH = 4).
module tb_ama_riscv_decode_queue;
    import ama_riscv_pkg::*;

    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH + 2);

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc;
    decoder_t         out_decoded;
    fe_ctrl_t         out_fe_ctrl;
    logic             out_illegal;
    logic [OCC_W-1:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    ama_riscv_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_decoded (out_decoded),
        .out_fe_ctrl (out_fe_ctrl),
        .out_illegal (out_illegal),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // addi x1, x0, k
    function automatic logic [31:0] mk_addi(input int k);
        logic [11:0] imm;
        imm = k[11:0];
        return {imm, 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    localparam logic [31:0] JAL_X1 = 32'h0100_00EF;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;

        // ---------------- reset ----------------
        step();
        step();
        rst_n = 1'b1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        check_eq("rst_out_inst", 64'(out_inst), 64'h13);
        check_eq("rst_out_pc", 64'(out_pc), 64'd0);
        check_eq("rst_out_illegal", 64'(out_illegal), 64'd0);
        check_eq("rst_decoded", 64'(out_decoded), 64'(DECODER_INIT_VAL));
        check_eq("rst_fe_ctrl", 64'(out_fe_ctrl), 64'(FE_CTRL_INIT_VAL));

        // ---------------- bypass ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'h0050_0093;
        in_pc     = 32'h100;
        step();
        in_valid = 1'b0;
        check_eq("byp_out_valid", 64'(out_valid), 64'd1);
        check_eq("byp_out_pc", 64'(out_pc), 64'h100);
        check_eq("byp_out_inst", 64'(out_inst), 64'h0050_0093);
        check_eq("byp_rd_we", 64'(out_decoded.rd_we), 64'd1);
        check_eq("byp_alu_b_sel", 64'(out_decoded.alu_b_sel), 64'd1);
        check_eq("byp_illegal", 64'(out_illegal), 64'd0);
        check_eq("byp_occupancy", 64'(occupancy), 64'd1);
        step();
        check_eq("byp_drain_valid", 64'(out_valid), 64'd0);
        check_eq("byp_drain_occ", 64'(occupancy), 64'd0);

        // ---------------- backpressure: fill to DEPTH+1 ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_inst  = mk_addi(k);
            in_pc    = 32'h200 + 32'(4 * k);
            check_eq("bp_in_ready_pre", 64'(in_ready), 64'd1);
            step();
            check_eq("bp_occupancy", 64'(occupancy), 64'(k + 1));
        end
        check_eq("bp_full_in_ready", 64'(in_ready), 64'd0);
        in_inst = mk_addi(5);
        in_pc   = 32'h214;
        step();
        step();
        check_eq("bp_hold_occ", 64'(occupancy), 64'd5);
        check_eq("bp_hold_pc", 64'(out_pc), 64'h200);
        check_eq("bp_hold_inst", 64'(out_inst), 64'(mk_addi(0)));
        check_eq("bp_hold_in_ready", 64'(in_ready), 64'd0);

        // ---------------- full with simultaneous pop ----------------
        out_ready = 1'b1;
        step();
        check_eq("fp_occupancy", 64'(occupancy), 64'd4);
        check_eq("fp_in_ready", 64'(in_ready), 64'd1);
        check_eq("fp_out_pc", 64'(out_pc), 64'h204);
        // The sixth word is now accepted while another pops: occupancy holds
        step();
        in_valid = 1'b0;
        check_eq("pp_occupancy", 64'(occupancy), 64'd4);
        check_eq("pp_out_pc", 64'(out_pc), 64'h208);
        for (int k = 3; k < 6; k++) begin
            step();
            check_eq("drain_valid", 64'(out_valid), 64'd1);
            check_eq("drain_pc", 64'(out_pc), 64'h200 + 64'(4 * k));
            check_eq("drain_inst", 64'(out_inst), 64'(mk_addi(k)));
        end
        step();
        check_eq("drain_end_valid", 64'(out_valid), 64'd0);
        check_eq("drain_end_occ", 64'(occupancy), 64'd0);

        // ---------------- flush with push in same cycle ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_inst  = mk_addi(10 + k);
            in_pc    = 32'h300 + 32'(4 * k);
            step();
        end
        check_eq("fl_pre_occ", 64'(occupancy), 64'd3);
        flush   = 1'b1;
        in_inst = mk_addi(99);
        in_pc   = 32'h3F0;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl_occupancy", 64'(occupancy), 64'd0);
        check_eq("fl_out_valid", 64'(out_valid), 64'd0);
        check_eq("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check_eq("fl_no_ghost", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b1;
        in_inst  = mk_addi(20);
        in_pc    = 32'h400;
        step();
        in_valid = 1'b0;
        check_eq("fl_after_valid", 64'(out_valid), 64'd1);
        check_eq("fl_after_pc", 64'(out_pc), 64'h400);
        step();

        // ---------------- illegal instructions ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h0000_0000;
        in_pc     = 32'h500;
        step();
        in_inst = 32'hFFFF_FFFF;
        in_pc   = 32'h504;
        step();
        in_inst = JAL_X1;
        in_pc   = 32'h508;
        step();
        in_valid = 1'b0;
        check_eq("il_occupancy", 64'(occupancy), 64'd3);
        out_ready = 1'b1;
        check_eq("il0_pc", 64'(out_pc), 64'h500);
        check_eq("il0_illegal", 64'(out_illegal), 64'd1);
        check_eq("il0_decoded", 64'(out_decoded), 64'(DECODER_INIT_VAL));
        check_eq("il0_fe_ctrl", 64'(out_fe_ctrl), 64'(FE_CTRL_INIT_VAL));
        step();
        check_eq("il1_pc", 64'(out_pc), 64'h504);
        check_eq("il1_inst", 64'(out_inst), 64'hFFFF_FFFF);
        check_eq("il1_illegal", 64'(out_illegal), 64'd1);
        check_eq("il1_decoded", 64'(out_decoded), 64'(DECODER_INIT_VAL));
        check_eq("il1_fe_ctrl", 64'(out_fe_ctrl), 64'(FE_CTRL_INIT_VAL));
        step();
        check_eq("jal_pc", 64'(out_pc), 64'h508);
        check_eq("jal_illegal", 64'(out_illegal), 64'd0);
        check_eq("jal_pc_sel", 64'(out_fe_ctrl.pc_sel), 64'(PC_SEL_JAL_BP));
        check_eq("jal_rd_we", 64'(out_decoded.rd_we), 64'd1);
        step();
        check_eq("il_end_valid", 64'(out_valid), 64'd0);

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = mk_addi(30);
        in_pc     = 32'h600;
        step();
        in_inst = mk_addi(31);
        in_pc   = 32'h604;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mrst_occupancy", 64'(occupancy), 64'd0);
        check_eq("mrst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mrst_in_ready", 64'(in_ready), 64'd1);
        check_eq("mrst_out_inst", 64'(out_inst), 64'h13);
        check_eq("mrst_out_pc", 64'(out_pc), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ama_riscv_decode_queue.md
# ama_riscv_decode_queue

Parametrised instruction buffer and registered decode stage between fetch and execute. Holds up to DEPTH fetched {inst, pc} pairs in a circular FIFO and decodes the head through an internal `ama_riscv_decoder` instance. The decoded bundle is delivered from an output register under a valid/ready handshake. It adds what the bare combinational decoder lacks: buffering, backpressure, flush, illegal-instruction flagging and occupancy reporting.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  discard all buffered and output-stage contents.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  queue can accept; registered, no combinational path from `out_ready`.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  32  PC of `in_inst`.
- `out_valid`  out  1  output register holds a decoded instruction.
- `out_ready`  in  1  execute consumes the output.
- `out_inst`  out  32  instruction in the output register.
- `out_pc`  out  32  its PC.
- `out_decoded`  out  decoder_t  decoded control bundle.
- `out_fe_ctrl`  out  fe_ctrl_t  frontend control bundle.
- `out_illegal`  out  1  instruction is not in the supported ISA.
- `occupancy`  out  $clog2(DEPTH+2)  FIFO entries plus `out_valid`, range 0..DEPTH+1.

## Operation
- Push: `in_valid && in_ready && !flush`.
- Pop: `out_valid && out_ready`.
- FIFO: write and read pointers of $clog2(DEPTH) bits with a separate entry count. Pointers wrap modulo DEPTH.
- Output register load: the register loads when `!out_valid || pop`.
  - Source is the FIFO head if the FIFO is non-empty.
  - Otherwise the input is bypassed directly when pushing. Bypassed instructions do not enter the FIFO.
  - Otherwise `out_valid` clears.
- Decode: the decoder evaluates combinationally on the selected source word. `out_decoded`, `out_fe_ctrl` and `out_illegal` are registered with the word.
- Ordering: strict FIFO order is kept. Bypass happens only when the FIFO is empty.
- Illegal: `out_illegal=1` if `inst[1:0]!=2'b11`, or if the opcode is none of R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, CUSTOM, SYSTEM.
  - Illegal words still flow through the queue.
  - Their bundles are `DECODER_INIT_VAL` / `FE_CTRL_INIT_VAL`.
- `in_ready = (fifo_count < DEPTH)`, computed from registered state.
  - A pop in the same cycle does not raise `in_ready` when the FIFO is full.
- Flush:
  - Next cycle: FIFO count 0, pointers 0, `out_valid=0`, `occupancy=0`.
  - A push attempted in the flush cycle is dropped.
  - `flush` has priority over push and pop.
  - `in_ready` is unaffected by `flush`.
- Reset (`rst_n=0` at an edge):
  - Next cycle: `out_valid=0`, `in_ready=1`, `occupancy=0`, `out_inst=32'h0000_0013`, `out_pc=0`, `out_illegal=0`.
  - Bundles are at their INIT values; pointers and count are 0.
  - Reset mid-stream loses all contents, the same as flush.

## Timing
- Latency: a push at edge N into an empty queue with a free output register gives `out_valid=1` after edge N (visible in cycle N+1).
  - Via the FIFO, the instruction appears one cycle after the output register frees.
- Throughput: one instruction per cycle with `out_ready` held high.
- Push and pop in the same cycle leave `occupancy` unchanged.
- Full state:
  - FIFO holds DEPTH entries plus one in the output register, so `occupancy=DEPTH+1`.
  - `in_ready` returns to 1 the cycle after the first pop.
- Empty queue with `in_valid=0`: `out_valid` clears the cycle after the last pop.
- Handshake rule: `out_*` are stable while `out_valid && !out_ready`.

## Test plan
- Reset with `rst_n=0` for 2 cycles, then release.
  - Required: `out_valid=0`, `in_ready=1`, `occupancy=0`, `out_inst=32'h00000013`.
- Bypass: push `addi x1,x0,5` (32'h00500093) at PC 32'h100 with `out_ready=1`.
  - Required next cycle: `out_valid=1`, `out_pc=32'h100`, `out_decoded.rd_we=1`, `out_illegal=0`, `occupancy=1`.
- Backpressure with DEPTH=4 and `out_ready=0`: push 6 instructions.
  - Required: first 5 accepted; `in_ready=0` once `occupancy=5`; 6th held until `out_ready=1`.
  - Required: all 6 then drained in order with matching PCs.
- Full with simultaneous pop: at `occupancy=5`, assert `out_ready=1` and `in_valid=1`.
  - Required: that cycle no push (`in_ready=0`) and the pop occurs; next cycle `in_ready=1`, `occupancy=4`.
- Flush with `occupancy=3` and a push in the same cycle.
  - Required next cycle: `occupancy=0` and `out_valid=0`; the pushed instruction never appears at the output.
- Illegal: push 32'h0000_0000 and 32'hFFFF_FFFF, then a JAL.
  - Required: first two exit in order with `out_illegal=1` and INIT bundles.
  - Required: JAL exits with `out_illegal=0` and `out_fe_ctrl.pc_sel=PC_SEL_JAL_BP`.
